// File: rtl/fp_pkg.sv
// Shared floating-point constants and the round-to-nearest-even decision
// used by the adder datapath rounding blocks.
package fp_pkg;

    localparam int FP_WIDTH       = 24;
    localparam int FP_SHIFT_WIDTH = 5;
    localparam int FP_EXP_WIDTH   = 8;

    localparam logic [FP_EXP_WIDTH-1:0] EXP_MAX  = '1;
    localparam logic [FP_EXP_WIDTH-1:0] EXP_BIAS = 8'd127;

    // Bit positions of guard/round/sticky at the bottom of {M,G,R,S}
    localparam int GRS_S = 0;
    localparam int GRS_R = 1;
    localparam int GRS_G = 2;

    function automatic logic rne_round_up(input logic lsb, input logic g,
                                          input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero count over width+2 bits ({M,G,R}).
// An all-zero input reports width+2 together with all_zero_o.
module leading_zero_counter #(
    parameter int width       = 24,
    parameter int shift_width = 5
) (
    input  logic [width+1:0]       data_i,
    output logic [shift_width-1:0] count_o,
    output logic                   all_zero_o
);

    always_comb begin
        count_o    = shift_width'(width + 2);
        all_zero_o = ~|data_i;
        // Later (higher) set bits win, leaving the count of the MSB-most one
        for (int i = 0; i < width + 2; i++) begin
            if (data_i[i]) begin
                count_o = shift_width'(width + 1 - i);
            end
        end
    end

endmodule

// File: rtl/normalize_round.sv
// Post-addition normalizer and RNE rounder: stage 1 renormalizes the raw sum,
// stage 2 rounds and saturates; two-entry valid/ready pipeline.
module normalize_round
    import fp_pkg::*;
#(
    parameter int width       = FP_WIDTH,
    parameter int shift_width = FP_SHIFT_WIDTH,
    parameter int exp_width   = FP_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width+3:0]     in_mant,
    input  logic [exp_width-1:0] in_exp,
    input  logic                 in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [width-1:0]     out_mant,
    output logic [exp_width-1:0] out_exp,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_overflow,
    output logic                 out_underflow
);

    localparam int MW = width + 3;      // {M,G,R,S}
    localparam int EW = exp_width + 2;  // signed working exponent
    localparam logic [EW-1:0] EXP_SAT = {2'b00, {exp_width{1'b1}}};

    logic                 s1_valid_q, s2_valid_q;
    logic                 s1_load, s2_load;

    logic [MW-1:0]        s1_mant_q, s1_mant_d;
    logic [exp_width:0]   s1_exp_q, s1_exp_d;
    logic                 s1_sign_q;
    logic                 s1_zero_q, s1_zero_d;
    logic                 s1_unf_q, s1_unf_d;

    logic [width-1:0]     out_mant_q, out_mant_d;
    logic [exp_width-1:0] out_exp_q, out_exp_d;
    logic                 out_sign_q;
    logic                 out_zero_q, out_zero_d;
    logic                 out_ovf_q, out_ovf_d;
    logic                 out_unf_q, out_unf_d;

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = !rst && s1_load;
    assign out_valid = s2_valid_q;

    // ---------------- stage 1: normalize ----------------
    logic                   c_bit;
    logic [MW-1:0]          mgrs;
    logic [shift_width-1:0] lzc;
    logic                   mgr_zero;
    logic [MW-1:0]          norm_mant;
    logic signed [EW-1:0]   exp_ext;

    assign c_bit = in_mant[width+3];
    assign mgrs  = in_mant[MW-1:0];

    leading_zero_counter #(
        .width       (width),
        .shift_width (shift_width)
    ) u_lzc (
        .data_i     (in_mant[width+2:1]),
        .count_o    (lzc),
        .all_zero_o (mgr_zero)
    );

    // Logarithmic left shifter, mirror image of the alignment shifter
    always_comb begin
        norm_mant = mgrs;
        for (int k = 0; k < shift_width; k++) begin
            if (lzc[k]) begin
                norm_mant = norm_mant << (1 << k);
            end
        end
    end

    assign exp_ext = $signed({2'b00, in_exp}) - $signed({{(EW-shift_width){1'b0}}, lzc});

    always_comb begin
        s1_mant_d = norm_mant;
        s1_exp_d  = exp_ext[exp_width:0];
        s1_zero_d = 1'b0;
        s1_unf_d  = 1'b0;
        if (!c_bit && mgr_zero && !in_mant[GRS_S]) begin
            s1_mant_d = '0;
            s1_exp_d  = '0;
            s1_zero_d = 1'b1;
        end else if (c_bit) begin
            s1_mant_d = {in_mant[width+3:2], in_mant[GRS_R] | in_mant[GRS_S]};
            s1_exp_d  = {1'b0, in_exp} + (exp_width+1)'(1);
        end else if (exp_ext[EW-1] || (exp_ext == '0)) begin
            s1_mant_d = '0;
            s1_exp_d  = '0;
            s1_zero_d = 1'b1;
            s1_unf_d  = 1'b1;
        end
    end

    // ---------------- stage 2: round and saturate ----------------
    logic [width-1:0] s1_m;
    logic             round_up;
    logic [width:0]   sum;
    logic [EW-1:0]    exp_r;
    logic [width-1:0] mant_r;

    assign s1_m     = s1_mant_q[MW-1:3];
    assign round_up = rne_round_up(s1_m[0], s1_mant_q[GRS_G], s1_mant_q[GRS_R], s1_mant_q[GRS_S]);
    assign sum      = {1'b0, s1_m} + {{width{1'b0}}, round_up};
    assign exp_r    = {1'b0, s1_exp_q} + {{(exp_width+1){1'b0}}, sum[width]};
    assign mant_r   = sum[width] ? {1'b1, {(width-1){1'b0}}} : sum[width-1:0];

    always_comb begin
        out_mant_d = mant_r;
        out_exp_d  = exp_r[exp_width-1:0];
        out_zero_d = 1'b0;
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        if (s1_zero_q) begin
            out_mant_d = '0;
            out_exp_d  = '0;
            out_zero_d = 1'b1;
            out_unf_d  = s1_unf_q;
        end else if (exp_r >= EXP_SAT) begin
            out_mant_d = '0;
            out_exp_d  = '1;
            out_ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_unf_q   <= 1'b0;
            out_mant_q <= '0;
            out_exp_q  <= '0;
            out_sign_q <= 1'b0;
            out_zero_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_unf_q  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_mant_q <= s1_mant_d;
                    s1_exp_q  <= s1_exp_d;
                    s1_sign_q <= in_sign;
                    s1_zero_q <= s1_zero_d;
                    s1_unf_q  <= s1_unf_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_mant_q <= out_mant_d;
                    out_exp_q  <= out_exp_d;
                    out_sign_q <= s1_sign_q;
                    out_zero_q <= out_zero_d;
                    out_ovf_q  <= out_ovf_d;
                    out_unf_q  <= out_unf_d;
                end
            end
        end
    end

    assign out_mant      = out_mant_q;
    assign out_exp       = out_exp_q;
    assign out_sign      = out_sign_q;
    assign out_zero      = out_zero_q;
    assign out_overflow  = out_ovf_q;
    assign out_underflow = out_unf_q;

endmodule
